// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak message feeder: FSM state encoding and lane geometry.
package keccak_pkg;

    localparam int LANE_W         = 64;
    localparam int BYTES_PER_LANE = 8;
    localparam int LANE_IDX_W     = $clog2(BYTES_PER_LANE);
    localparam int HASH_W_DEF     = 512;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        FEED = 3'd2,
        LAST = 3'd3,
        WAIT = 3'd4
    } feeder_state_t;

endpackage

// File: rtl/keccak_len_ctrl.sv
// Message length bookkeeping: remaining stream words (ceil of length/8) and the final-word byte count.
module keccak_len_ctrl
    import keccak_pkg::*;
#(
    parameter int LEN_W = 32,
    parameter int WL_W  = LEN_W - LANE_IDX_W + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [LEN_W-1:0]      msg_len,
    input  logic                  consume,
    output logic [WL_W-1:0]       words_left,
    output logic [LANE_IDX_W-1:0] rem,
    output logic                  final_word,
    output logic                  need_empty_last,
    output logic                  words_done
);

    localparam logic [WL_W-1:0] ONE = {{(WL_W-1){1'b0}}, 1'b1};

    logic [WL_W-1:0] full_words;
    logic [WL_W-1:0] partial_word;

    assign full_words   = {1'b0, msg_len[LEN_W-1:LANE_IDX_W]};
    assign partial_word = {{(WL_W-1){1'b0}}, |msg_len[LANE_IDX_W-1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            words_left <= '0;
            rem        <= '0;
        end else if (load) begin
            words_left <= full_words + partial_word;
            rem        <= msg_len[LANE_IDX_W-1:0];
        end else if (consume && words_left != '0) begin
            words_left <= words_left - ONE;
        end
    end

    // A word is only "final" in the is_last sense when it is partial; a full last word
    // is followed by a separate empty last word.
    assign final_word      = (words_left == ONE) && (rem != '0);
    assign need_empty_last = (rem == '0);
    assign words_done      = (words_left == '0);

endmodule

// File: rtl/keccak_msg_feeder.sv
// Feeds a 64-bit word stream into the Keccak core message port and captures the digest.
// Optional start-to-done cycle counter enabled by defining FEEDER_PERF_CNT_EN.
module keccak_msg_feeder
    import keccak_pkg::*;
#(
    parameter int LEN_W  = 32,
    parameter int HASH_W = HASH_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_W-1:0]      msg_len,
    input  logic [LANE_W-1:0]     s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  keccak_rst,
    output logic [LANE_W-1:0]     keccak_in,
    output logic                  keccak_in_ready,
    output logic                  keccak_is_last,
    output logic [LANE_IDX_W-1:0] keccak_byte_num,
    input  logic                  keccak_buffer_full,
    input  logic [HASH_W-1:0]     keccak_out,
    input  logic                  keccak_out_ready,
    output logic [HASH_W-1:0]     hash,
    output logic                  hash_valid,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           cycle_count
);

    localparam int WL_W = LEN_W - LANE_IDX_W + 1;

    feeder_state_t state, next_state;

    logic [WL_W-1:0]       words_left;
    logic [LANE_IDX_W-1:0] rem;
    logic                  final_word;
    logic                  need_empty_last;
    logic                  words_done;
    logic                  start_acc;
    logic                  accept;
    logic                  last_issue;
    logic                  digest_hit;

    assign start_acc  = (state == IDLE) && start;
    // Waiting for in_ready to drop keeps the core's buffer_full current before the next word.
    assign s_ready    = (state == FEED) && !words_done && !keccak_buffer_full && !keccak_in_ready;
    assign accept     = s_valid && s_ready;
    assign last_issue = (state == LAST) && !keccak_buffer_full && !keccak_in_ready;
    assign digest_hit = (state == WAIT) && keccak_out_ready;

    keccak_len_ctrl #(
        .LEN_W(LEN_W),
        .WL_W (WL_W)
    ) u_len_ctrl (
        .clk            (clk),
        .reset          (reset),
        .load           (start_acc),
        .msg_len        (msg_len),
        .consume        (accept),
        .words_left     (words_left),
        .rem            (rem),
        .final_word     (final_word),
        .need_empty_last(need_empty_last),
        .words_done     (words_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = CLR;
            CLR:  next_state = FEED;
            FEED: begin
                if (accept && final_word) begin
                    next_state = WAIT;
                end else if (words_done && need_empty_last) begin
                    next_state = LAST;
                end
            end
            LAST: if (last_issue) next_state = WAIT;
            WAIT: if (keccak_out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            keccak_rst      <= 1'b0;
            keccak_in       <= '0;
            keccak_in_ready <= 1'b0;
            keccak_is_last  <= 1'b0;
            keccak_byte_num <= '0;
            hash            <= '0;
            hash_valid      <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            keccak_rst      <= start_acc;
            keccak_in_ready <= accept || last_issue;
            keccak_is_last  <= (accept && final_word) || last_issue;
            keccak_byte_num <= (accept && final_word) ? rem : '0;
            busy            <= (next_state != IDLE);
            done            <= digest_hit;
            if (accept) begin
                keccak_in <= s_data;
            end else if (last_issue) begin
                keccak_in <= '0;
            end
            if (start_acc) begin
                hash_valid <= 1'b0;
            end else if (digest_hit) begin
                hash       <= keccak_out;
                hash_valid <= 1'b1;
            end
        end
    end

`ifdef FEEDER_PERF_CNT_EN
    // Counting through the WAIT cycle that sees the digest makes the total match start-to-done.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (start_acc) begin
            cycle_count <= '0;
        end else if (state != IDLE) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`else
    assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_keccak_msg_feeder.sv
// Directed self-checking bench for keccak_msg_feeder.
module tb_keccak_msg_feeder;

    localparam int LEN_W  = 32;
    localparam int HASH_W = 512;

    logic              clk;
    logic              reset;
    logic              start;
    logic [LEN_W-1:0]  msg_len;
    logic [63:0]       s_data;
    logic              s_valid;
    logic              s_ready;
    logic              keccak_rst;
    logic [63:0]       keccak_in;
    logic              keccak_in_ready;
    logic              keccak_is_last;
    logic [2:0]        keccak_byte_num;
    logic              keccak_buffer_full;
    logic [HASH_W-1:0] keccak_out;
    logic              keccak_out_ready;
    logic [HASH_W-1:0] hash;
    logic              hash_valid;
    logic              busy;
    logic              done;
    logic [31:0]       cycle_count;

    keccak_msg_feeder #(
        .LEN_W (LEN_W),
        .HASH_W(HASH_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .msg_len           (msg_len),
        .s_data            (s_data),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .keccak_rst        (keccak_rst),
        .keccak_in         (keccak_in),
        .keccak_in_ready   (keccak_in_ready),
        .keccak_is_last    (keccak_is_last),
        .keccak_byte_num   (keccak_byte_num),
        .keccak_buffer_full(keccak_buffer_full),
        .keccak_out        (keccak_out),
        .keccak_out_ready  (keccak_out_ready),
        .hash              (hash),
        .hash_valid        (hash_valid),
        .busy              (busy),
        .done              (done),
        .cycle_count       (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    logic [63:0] src_words [8];
    int src_len = 0;
    int src_idx = 0;
    bit hs_flag = 0;
    int hs_count, rst_count, done_count, sready_seen;
    logic [63:0] rec_data [$];
    bit          rec_last [$];
    logic [2:0]  rec_bn   [$];
    int          rec_cyc  [$];

    logic [HASH_W-1:0] dig_a5;
    logic [HASH_W-1:0] dig_other;

    task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at the falling edge, then update the stream source just after the rising edge.
    task automatic applyStimulus();
        @(negedge clk);
        if (keccak_in_ready) begin
            rec_data.push_back(keccak_in);
            rec_last.push_back(keccak_is_last);
            rec_bn.push_back(keccak_byte_num);
            rec_cyc.push_back(cyc);
        end
        if (s_valid && s_ready) begin
            hs_count++;
            hs_flag = 1;
        end
        if (s_ready) sready_seen++;
        if (keccak_rst) rst_count++;
        if (done) begin
            done_count++;
            done_cyc = cyc;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (hs_flag) begin
            src_idx++;
            hs_flag = 0;
        end
        s_valid = (src_idx < src_len);
        s_data  = (src_idx < src_len) ? src_words[src_idx] : 64'd0;
    endtask

    task automatic clearMonitors();
        hs_count = 0;
        rst_count = 0;
        done_count = 0;
        sready_seen = 0;
        rec_data.delete();
        rec_last.delete();
        rec_bn.delete();
        rec_cyc.delete();
    endtask

    task automatic startMessage(input int len, input int nwords);
        clearMonitors();
        src_len = nwords;
        src_idx = 0;
        hs_flag = 0;
        msg_len = len;
        start = 1'b1;
        applyStimulus();
        start_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic waitRecords(input int n, input string tag);
        int budget = 60;
        while (rec_data.size() < n && budget > 0) begin
            applyStimulus();
            budget--;
        end
        checkOutput({tag, "_pulses"}, rec_data.size(), n);
    endtask

    task automatic finishDigest(input logic [HASH_W-1:0] d);
        keccak_out = d;
        keccak_out_ready = 1'b1;
        applyStimulus();
        keccak_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus();
    endtask

    initial begin
        int base_rec, base_hs, base_sr;
        dig_a5    = {64{8'hA5}};
        dig_other = {64{8'h3C}};
        reset = 1'b1;
        start = 1'b0;
        msg_len = '0;
        s_data = '0;
        s_valid = 1'b0;
        keccak_buffer_full = 1'b0;
        keccak_out = '0;
        keccak_out_ready = 1'b0;
        clearMonitors();
        applyStimulus();
        applyStimulus();
        checkOutput("rst_outputs", {keccak_rst, keccak_in_ready, keccak_is_last, keccak_byte_num,
                                    hash_valid, busy, done, s_ready}, 0);
        checkOutput("rst_in_hash", {keccak_in, hash[63:0], cycle_count}, 0);
        reset = 1'b0;
        applyStimulus();

        // Two full words followed by an empty last word.
        src_words[0] = 64'h0011223344556677;
        src_words[1] = 64'h8899AABBCCDDEEFF;
        startMessage(16, 2);
        waitRecords(3, "len16");
        checkOutput("len16_rst", rst_count, 1);
        checkOutput("len16_hs", hs_count, 2);
        checkOutput("len16_w0", rec_data[0], 64'h0011223344556677);
        checkOutput("len16_w1", rec_data[1], 64'h8899AABBCCDDEEFF);
        checkOutput("len16_gap", rec_cyc[1] - rec_cyc[0], 2);
        checkOutput("len16_notlast", {rec_last[0], rec_last[1]}, 0);
        checkOutput("len16_last", {rec_last[2], rec_bn[2]}, {1'b1, 3'd0});
        checkOutput("len16_empty", rec_data[2], 0);
        finishDigest(dig_other);
        checkOutput("len16_done", done_count, 1);

        // Partial final word carries is_last with byte count.
        src_words[0] = 64'hDEADBEEF01020304;
        src_words[1] = 64'hCAFEF00D55667788;
        startMessage(13, 2);
        checkOutput("len13_hv_clr", hash_valid, 0);
        waitRecords(2, "len13");
        for (int i = 0; i < 6; i++) applyStimulus();
        checkOutput("len13_noempty", rec_data.size(), 2);
        checkOutput("len13_w0", {rec_last[0], rec_data[0]}, {1'b0, 64'hDEADBEEF01020304});
        checkOutput("len13_w1", {rec_last[1], rec_bn[1], rec_data[1]}, {1'b1, 3'd5, 64'hCAFEF00D55667788});
        finishDigest(dig_a5);
        checkOutput("len13_hash", hash, dig_a5);
        checkOutput("len13_done", done_count, 1);
        for (int i = 0; i < 4; i++) applyStimulus();
        checkOutput("len13_hv", {hash_valid, busy}, 2'b10);

        // Digest strobe while idle must be ignored.
        clearMonitors();
        finishDigest(dig_other);
        checkOutput("idle_outrdy_hash", hash, dig_a5);
        checkOutput("idle_outrdy_done", done_count, 0);

        // Zero-length message: only the empty last word.
        startMessage(0, 0);
        waitRecords(1, "len0");
        for (int i = 0; i < 4; i++) applyStimulus();
        checkOutput("len0_sready", sready_seen, 0);
        checkOutput("len0_count", rec_data.size(), 1);
        checkOutput("len0_last", {rec_last[0], rec_bn[0]}, {1'b1, 3'd0});
        finishDigest(dig_other);

        // Core buffer full after the first word stalls issue.
        src_words[0] = 64'h1111111111111111;
        src_words[1] = 64'h2222222222222222;
        src_words[2] = 64'h3333333333333333;
        startMessage(24, 3);
        waitRecords(1, "len24a");
        keccak_buffer_full = 1'b1;
        base_rec = rec_data.size();
        base_hs  = hs_count;
        base_sr  = sready_seen;
        for (int i = 0; i < 10; i++) applyStimulus();
        checkOutput("hold_inrdy", rec_data.size() - base_rec, 0);
        checkOutput("hold_hs", hs_count - base_hs, 0);
        checkOutput("hold_sready", sready_seen - base_sr, 0);
        keccak_buffer_full = 1'b0;
        waitRecords(4, "len24b");
        checkOutput("len24_order", {rec_data[1], rec_data[2]},
                    {64'h2222222222222222, 64'h3333333333333333});
        checkOutput("len24_last", {rec_last[3], rec_data[3], rec_last[2]}, {1'b1, 64'd0, 1'b0});
        checkOutput("len24_hs", hs_count, 3);
        finishDigest(dig_other);

        // Reset in the middle of a message, then a fresh 8-byte message.
        startMessage(24, 3);
        waitRecords(1, "midrst");
        reset = 1'b1;
        applyStimulus();
        checkOutput("midrst_outputs", {keccak_rst, keccak_in_ready, keccak_is_last, keccak_byte_num,
                                       hash_valid, busy, done, s_ready}, 0);
        checkOutput("midrst_data", {keccak_in, hash[63:0], cycle_count}, 0);
        reset = 1'b0;
        applyStimulus();
        src_words[0] = 64'hABCDEF0123456789;
        startMessage(8, 1);
        waitRecords(2, "len8");
        checkOutput("len8_w0", {rec_last[0], rec_data[0]}, {1'b0, 64'hABCDEF0123456789});
        checkOutput("len8_last", {rec_last[1], rec_bn[1], rec_data[1]}, {1'b1, 3'd0, 64'd0});
        checkOutput("len8_hs", hs_count, 1);
        for (int i = 0; i < 20; i++) applyStimulus();
        finishDigest(dig_a5);
        checkOutput("len8_done", done_count, 1);
`ifdef FEEDER_PERF_CNT_EN
        checkOutput("perf_count", cycle_count, done_cyc - start_cyc);
        for (int i = 0; i < 5; i++) applyStimulus();
        checkOutput("perf_hold", cycle_count, done_cyc - start_cyc);
`else
        checkOutput("perf_off", cycle_count, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keccak_msg_feeder.md
Name: keccak_msg_feeder

Overview:
- Downstream of the bus-FIFO drain stage; consumes its 64-bit word stream and drives the Keccak core message interface (in, in_ready, is_last, byte_num, buffer_full).
- Handles final-word byte count and the empty-final-word rule; pulses the core's reset before each message.
- Captures the 512-bit digest and presents it to the AXI master/slave logic with a done pulse.

Parameters:
- LEN_W, 32, width of message length in bytes
- HASH_W, 512, digest width captured from the core

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  begin a message; sampled only in IDLE
- msg_len  in  LEN_W  message length in bytes, sampled when start is accepted
- s_data  in  64  stream word, byte 0 in bits [63:56]
- s_valid  in  1  s_data valid
- s_ready  out  1  feeder accepts s_data this cycle
- keccak_rst  out  1  one-cycle reset pulse to core
- keccak_in  out  64  word to core
- keccak_in_ready  out  1  keccak_in valid, one-cycle pulse per word
- keccak_is_last  out  1  qualifies final keccak_in_ready pulse
- keccak_byte_num  out  3  valid bytes in final word (0..7)
- keccak_buffer_full  in  1  core cannot accept a word
- keccak_out  in  HASH_W  digest from core
- keccak_out_ready  in  1  digest valid
- hash  out  HASH_W  latched digest
- hash_valid  out  1  hash holds result of last message
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when hash latched
- cycle_count  out  32  start-to-done cycles (see Optional Feature)

Behaviour:
- Reset: state IDLE; every output 0, including hash, hash_valid, s_ready, keccak_*.
- All outputs registered except s_ready (combinational from state/counters/keccak_buffer_full/keccak_in_ready).
- On start accept: full_words = msg_len >> 3, rem = msg_len[2:0]; hash_valid cleared.
- States:
  - IDLE: start -> CLR; start in any other state ignored.
  - CLR: keccak_rst = 1 for exactly one cycle -> FEED.
  - FEED: s_ready = words_left != 0 && !keccak_buffer_full && !keccak_in_ready (max one word per two cycles, so core buffer_full is never stale).
    - On s_valid && s_ready: keccak_in <= s_data; keccak_in_ready <= 1 next cycle; decrement counter.
    - Non-final word: is_last = 0.
    - Final word with rem != 0: is_last = 1, byte_num = rem -> WAIT.
    - All full words sent and rem == 0 -> LAST.
  - LAST: when !keccak_buffer_full && !keccak_in_ready, issue is_last = 1, byte_num = 0, keccak_in = 0, without consuming a stream word -> WAIT.
  - WAIT: on keccak_out_ready, hash <= keccak_out, hash_valid <= 1, done <= 1 -> IDLE.
- Word counter: ceil(msg_len/8) stream words consumed per message, never more. s_ready = 0 outside FEED.
- msg_len = 0: CLR -> FEED with 0 words -> LAST (single empty final word).
- Stream stall (s_valid = 0) holds FEED indefinitely. keccak_buffer_full high blocks issue; no word is lost or duplicated.
- keccak_out_ready outside WAIT: ignored.
- Reset mid-message: immediate return to IDLE; partial state and counters discarded.

Optional Feature:
- Macro FEEDER_PERF_CNT_EN.
- Defined: cycle_count clears on start accept, increments every cycle while busy, and freezes when done pulses.
- Undefined: cycle_count tied to 0; no counter logic.

Decomposition:
- Shared package keccak_pkg: state encoding constants (IDLE, CLR, FEED, LAST, WAIT), LANE_W = 64, BYTES_PER_LANE = 8, HASH_W default.
- One sub-module natural: keccak_len_ctrl. Owns the words_left/rem counters and produces final-word and need-empty-last flags. The FSM stays in the top module.

Test Plan:
- msg_len = 16, two words streamed back-to-back -> keccak_rst once; two in_ready pulses two cycles apart; then is_last with byte_num = 0 and keccak_in = 0; 3 pulses total; 2 s_data handshakes.
- msg_len = 13, two words -> second word carries is_last = 1, byte_num = 5; no empty word; then keccak_out_ready with digest 0xA5…A5 -> hash = 0xA5…A5, done one cycle, hash_valid stays 1.
- msg_len = 0 -> no s_ready assertion; exactly one in_ready pulse with is_last = 1, byte_num = 0.
- msg_len = 24, keccak_buffer_full held high 10 cycles after word 1 -> no in_ready during hold; words 2–3 delivered in order after release; s_ready low throughout the hold.
- Reset asserted mid-FEED after 1 of 3 words -> all outputs 0 next cycle; new start with msg_len = 8 completes normally with one full word plus an empty last word.
- FEEDER_PERF_CNT_EN defined, msg_len = 8, no stalls, out_ready 20 cycles after last word -> cycle_count equals measured start-to-done cycles and holds after done.
